// File: rtl/xdma_app.sv
// xdma_app: H2C AXI-Stream beats buffered in a FWFT FIFO and looped back on C2H, framed every PKT_BEATS beats.
// Latency: 1 cycle from H2C acceptance to C2H presentation when the buffer was empty.
// Backpressure: s_axis_h2c_tready = !full; C2H outputs hold while tvalid & !tready. Macro APP_IRQ_EN enables irq_req/irq_ack.
module xdma_app #(
  parameter int TCQ             = 1,
  parameter int DATA_WIDTH      = 128,
  parameter int BYTE_BIT_ENABLE = 16,
  parameter int FIFO_DEPTH      = 64,
  parameter int PKT_BEATS       = 32
) (
  input  logic                       user_clk,
  input  logic                       user_rst,
  input  logic [DATA_WIDTH-1:0]      s_axis_h2c_tdata,
  input  logic                       s_axis_h2c_tlast,
  input  logic                       s_axis_h2c_tvalid,
  output logic                       s_axis_h2c_tready,
  input  logic [BYTE_BIT_ENABLE-1:0] s_axis_h2c_tkeep,
  output logic [DATA_WIDTH-1:0]      m_axis_c2h_tdata,
  output logic                       m_axis_c2h_tlast,
  output logic                       m_axis_c2h_tvalid,
  input  logic                       m_axis_c2h_tready,
  output logic [BYTE_BIT_ENABLE-1:0] m_axis_c2h_tkeep,
  output logic                       irq_req,
  input  logic                       irq_ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int EW = BYTE_BIT_ENABLE + 1 + DATA_WIDTH;

  // A negative clock-to-Q value, a keep width that does not match the data width,
  // or a non power-of-2 depth (pointers wrap by truncation) is a configuration error.
  if (BYTE_BIT_ENABLE != DATA_WIDTH / 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TCQ < 0)
  begin : g_param_check
    $error("xdma_app: illegal parameter combination");
  end

  // Each entry is {tkeep, tlast_int, tdata}; storage has no reset so it can map to RAM.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tlast_int;
  logic [EW-1:0] head;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign tlast_int = s_axis_h2c_tlast || (cnt == CW'(PKT_BEATS - 1));

  // Both handshakes are masked while reset is asserted so nothing moves during reset.
  assign s_axis_h2c_tready = !full && !user_rst;
  assign m_axis_c2h_tvalid = !empty && !user_rst;
  assign push              = s_axis_h2c_tvalid && s_axis_h2c_tready;
  assign pop               = m_axis_c2h_tvalid && m_axis_c2h_tready;

  // First-word-fall-through: the head entry is always on the outputs, forced to zero when idle.
  assign head = mem[rd_ptr];
  assign {m_axis_c2h_tkeep, m_axis_c2h_tlast, m_axis_c2h_tdata} = m_axis_c2h_tvalid ? head : '0;

  // Write accepted H2C beats into storage.
  always_ff @(posedge user_clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_h2c_tkeep, tlast_int, s_axis_h2c_tdata};
    end
  end

  // Pointers and occupancy; reset drops every buffered beat.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame counter on the push side; any beat carrying tlast_int starts a new frame.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cnt <= '0;
    end else if (push) begin
      cnt <= tlast_int ? '0 : cnt + CW'(1);
    end
  end

`ifdef APP_IRQ_EN
  // Level interrupt per completed C2H frame; a new frame end beats a same-cycle acknowledge.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      irq_req <= 1'b0;
    end else if (pop && m_axis_c2h_tlast) begin
      irq_req <= 1'b1;
    end else if (irq_ack) begin
      irq_req <= 1'b0;
    end
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq_req        = 1'b0;
`endif

endmodule

// File: tb/tb_xdma_app.sv
// tb_xdma_app: directed vector table plus multi-cycle stream sequences for xdma_app.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 1 unit after it or on the falling edge.
// Expected data comes from hand-written constants and a small scoreboard of accepted beats.
`timescale 1ns/1ps
module tb_xdma_app;

  localparam int DW    = 128;
  localparam int KW    = 16;
  localparam int DEPTH = 64;
  localparam int PKT   = 32;
`ifdef APP_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  typedef logic [KW+DW:0] ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] h_data;
  logic          h_last;
  logic          h_vld;
  logic          h_rdy;
  logic [KW-1:0] h_keep;
  logic [DW-1:0] c_data;
  logic          c_last;
  logic          c_vld;
  logic          c_rdy;
  logic [KW-1:0] c_keep;
  logic          irq_req;
  logic          irq_ack;

  int total = 0;
  int bad   = 0;
  int lastpos[$];

  always #5 clk = ~clk;

  xdma_app #(
    .TCQ(1), .DATA_WIDTH(DW), .BYTE_BIT_ENABLE(KW), .FIFO_DEPTH(DEPTH), .PKT_BEATS(PKT)
  ) dut (
    .user_clk(clk),
    .user_rst(rst),
    .s_axis_h2c_tdata(h_data),
    .s_axis_h2c_tlast(h_last),
    .s_axis_h2c_tvalid(h_vld),
    .s_axis_h2c_tready(h_rdy),
    .s_axis_h2c_tkeep(h_keep),
    .m_axis_c2h_tdata(c_data),
    .m_axis_c2h_tlast(c_last),
    .m_axis_c2h_tvalid(c_vld),
    .m_axis_c2h_tready(c_rdy),
    .m_axis_c2h_tkeep(c_keep),
    .irq_req(irq_req),
    .irq_ack(irq_ack)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic checke(input string name, input ent_t act, input ent_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; h_vld = 1'b0; h_last = 1'b0; h_data = '0; h_keep = '0;
    c_rdy = 1'b0; irq_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Streams n beats (data = index) through the DUT, checking order, framing, stall stability and fill level.
  task automatic run_stream(input int n, input int tl_a, input int tl_b, input int hold,
                            input logic rnd, input logic chk_full);
    ent_t exp_q[$];
    ent_t stall_ent = '0;
    ent_t got_ent;
    logic stall_seen = 1'b0;
    logic full_checked = 1'b0;
    logic tl;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int mcnt = 0;
    lastpos.delete();
    while (got < n && cyc < 20000) begin
      h_vld  = (sent < n);
      h_data = DW'(sent);
      h_keep = KW'(sent * 3 + 1);
      h_last = (sent == tl_a) || (sent == tl_b);
      c_rdy  = (cyc >= hold) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      @(negedge clk);
      got_ent = {c_keep, c_last, c_data};
      if (stall_seen) begin
        check1("stall_vld", c_vld, 1'b1);
        checke("stall_hold", got_ent, stall_ent);
      end
      if (chk_full && !full_checked && sent == DEPTH && got == 0) begin
        check1("full_tready", h_rdy, 1'b0);
        full_checked = 1'b1;
      end
      if (h_vld && h_rdy) begin
        tl   = h_last || (mcnt == PKT - 1);
        mcnt = tl ? 0 : mcnt + 1;
        exp_q.push_back({h_keep, tl, h_data});
        sent++;
      end
      if (c_vld && c_rdy) begin
        if (exp_q.size() == 0) checkn("c2h_underflow", exp_q.size(), 1);
        else checke($sformatf("c2h_beat%0d", got), got_ent, exp_q.pop_front());
        if (c_last) lastpos.push_back(got);
        got++;
        stall_seen = 1'b0;
      end else begin
        stall_seen = c_vld;
        stall_ent  = got_ent;
      end
      @(posedge clk);
      #1 cyc++;
    end
    if (got < n) checkn("stream_timeout", got, n);
    if (chk_full) check1("full_seen", full_checked, 1'b1);
    h_vld = 1'b0;
    c_rdy = 1'b0;
    @(negedge clk);
    check1("stream_drained", c_vld, 1'b0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst, vld;
    logic [DW-1:0] dat;
    logic          last;
    logic [KW-1:0] keep;
    logic          rdy, ack;
    logic          e_hrdy, e_cvld;
    logic [DW-1:0] e_dat;
    logic          e_last;
    logic [KW-1:0] e_keep;
    logic          e_irq;
  } vec_t;

  vec_t vt[15];

  localparam logic [DW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] D2 = 128'hDEADBEEFCAFEF00D0011223344556677;
  localparam logic [DW-1:0] D3 = 128'h8899AABBCCDDEEFF7766554433221100;
  localparam logic [DW-1:0] D4 = 128'hFFFF0000FFFF00001234567812345678;

  initial begin
    int exp_a[3];
    int exp_b[2];
    exp_a = '{31, 63, 95};
    exp_b = '{4, 36};

    // Fields: rst vld dat last keep rdy ack | hrdy cvld dat last keep irq (checked 1 unit after the edge)
    for (int i = 0; i < 4; i++)
      vt[i] = '{1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, D1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, D1, 1'b0, 16'hFFFF, 1'b0};
    vt[6]  = '{1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, D2, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b1, D2, 1'b1, 16'h00FF, 1'b0};
    vt[8]  = '{1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, D2, 1'b1, 16'h00FF, 1'b0};
    vt[9]  = '{1'b0, 1'b1, D3, 1'b0, 16'h0F0F, 1'b1, 1'b0, 1'b1, 1'b1, D3, 1'b0, 16'h0F0F, IRQ_ON};
    vt[10] = '{1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, IRQ_ON};
    vt[11] = '{1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0};
    vt[12] = '{1'b0, 1'b1, D4, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, D4, 1'b0, 16'hFFFF, 1'b0};
    vt[13] = '{1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0};
    vt[14] = '{1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0};

    foreach (vt[i]) begin
      rst = vt[i].rst; h_vld = vt[i].vld; h_data = vt[i].dat; h_last = vt[i].last;
      h_keep = vt[i].keep; c_rdy = vt[i].rdy; irq_ack = vt[i].ack;
      @(posedge clk);
      #1;
      check1($sformatf("v%0d_h2c_tready", i), h_rdy, vt[i].e_hrdy);
      check1($sformatf("v%0d_c2h_tvalid", i), c_vld, vt[i].e_cvld);
      checke($sformatf("v%0d_c2h_beat", i), {c_keep, c_last, c_data},
             {vt[i].e_keep, vt[i].e_last, vt[i].e_dat});
      check1($sformatf("v%0d_irq_req", i), irq_req, vt[i].e_irq);
    end
    h_vld = 1'b0; c_rdy = 1'b0; irq_ack = 1'b0;

    // 113 beats against a stalled sink: fills at 64, forced tlast every 32 beats.
    do_reset();
    run_stream(113, -1, -1, 100, 1'b0, 1'b1);
    checkn("a_tlast_count", lastpos.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < lastpos.size()) checkn($sformatf("a_tlast_pos%0d", k), lastpos[k], exp_a[k]);

    // Host tlast on beat 4 restarts the frame counter.
    do_reset();
    run_stream(45, 4, -1, 0, 1'b0, 1'b0);
    checkn("b_tlast_count", lastpos.size(), 2);
    for (int k = 0; k < 2; k++)
      if (k < lastpos.size()) checkn($sformatf("b_tlast_pos%0d", k), lastpos[k], exp_b[k]);

    // Random sink backpressure over 500 beats.
    do_reset();
    run_stream(500, 200, -1, 0, 1'b1, 1'b0);

    // Interrupt: 32-beat frame drained, then acknowledge, then ack colliding with a new frame end.
    do_reset();
    h_vld = 1'b1; h_last = 1'b0; h_keep = '1;
    for (int i = 0; i < PKT; i++) begin
      h_data = DW'(1000 + i);
      @(posedge clk);
      #1;
    end
    h_vld = 1'b0;
    c_rdy = 1'b1;
    for (int i = 0; i < PKT; i++) begin
      @(negedge clk);
      if (i == PKT - 1) begin
        check1("irq_frame_tlast", c_last, 1'b1);
        check1("irq_before_pop", irq_req, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    c_rdy = 1'b0;
    @(negedge clk);
    check1("irq_after_frame", irq_req, IRQ_ON);
    check1("irq_fifo_empty", c_vld, 1'b0);
    @(posedge clk);
    #1 irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    @(negedge clk);
    check1("irq_cleared_by_ack", irq_req, 1'b0);
    @(posedge clk);
    #1;
    h_vld = 1'b1; h_last = 1'b1;
    h_data = DW'(7);
    @(posedge clk);
    #1 h_data = DW'(8);
    @(posedge clk);
    #1 h_vld = 1'b0; h_last = 1'b0;
    c_rdy = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b1;
    @(negedge clk);
    check1("irq_first_short_frame", irq_req, IRQ_ON);
    check1("irq_second_beat_last", c_last, 1'b1);
    @(posedge clk);
    #1 irq_ack = 1'b0; c_rdy = 1'b0;
    @(negedge clk);
    check1("irq_set_beats_ack", irq_req, IRQ_ON);
    check1("irq_short_drained", c_vld, 1'b0);
    @(posedge clk);
    #1 irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    @(negedge clk);
    check1("irq_final_clear", irq_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
